// File: rtl/find_top_bottom_pkg.sv
// Shared constants for the star-extent pipeline: image geometry, background level,
// coordinate widths and the top/bottom finder state encoding.
package find_top_bottom_pkg;

   localparam int XSZ       = 3;
   localparam int YSZ       = 3;
   localparam int ADDR_SZ   = 6;
   localparam int COL_SZ    = 3;
   localparam int WIDTH     = 6;
   localparam int HEIGHT    = 6;
   localparam int THRESHOLD = 0;

   localparam logic [XSZ-1:0]    X_LAST = XSZ'(WIDTH - 1);
   localparam logic [YSZ-1:0]    Y_LAST = YSZ'(HEIGHT - 1);
   localparam logic [COL_SZ-1:0] BG_VAL = COL_SZ'(THRESHOLD);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // The extra sum bit keeps (first + last) from wrapping before the halving.
   function automatic logic [XSZ-1:0] mid_of(input logic [XSZ-1:0] a, input logic [XSZ-1:0] b);
      logic [XSZ:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[XSZ:1];
   endfunction

endpackage

// File: rtl/find_top_bottom_address_translator.sv
// Raster address from pixel coordinates: y*WIDTH + x with WIDTH = 6 done as y*4 + y*2 + x.
module address_translator
   import find_top_bottom_pkg::*;
(
   input  logic [XSZ-1:0]     x,
   input  logic [YSZ-1:0]     y,
   output logic [ADDR_SZ-1:0] mem_address
);

   logic [ADDR_SZ-1:0] y_ext;
   logic [ADDR_SZ-1:0] x_ext;

   assign y_ext       = ADDR_SZ'(y);
   assign x_ext       = ADDR_SZ'(x);
   assign mem_address = (y_ext << 2) + (y_ext << 1) + x_ext;

endmodule

// File: rtl/find_top_bottom.sv
// Raster-scans the pixel RAM and reports the topmost/bottommost star rows and the
// midpoint column of the star pixels on the top row.
//
// state | meaning
// IDLE  | waiting for start; address held at 0
// SCAN  | one RAM read issued per cycle, x fastest
// DRAIN | consumes the read of the last pixel
// DONE  | results valid, done (and TopandBottomFound) pulse
module find_top_bottom
   import find_top_bottom_pkg::*;
(
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic [COL_SZ-1:0]  pixVal,
   output logic [ADDR_SZ-1:0] mem_address,
   output logic [YSZ-1:0]     mostTop,
   output logic [YSZ-1:0]     mostBottom,
   output logic [XSZ-1:0]     midPix,
   output logic               noStar,
   output logic               done,
   output logic               TopandBottomFound
);

   logic [1:0]         state_q, state_d;
   logic [XSZ-1:0]     x_q, x_d;
   logic [YSZ-1:0]     y_q, y_d;
   logic [XSZ-1:0]     x_dly_q;
   logic [YSZ-1:0]     y_dly_q;
   logic               v_dly_q;
   logic               found_q, found_d;
   logic [YSZ-1:0]     top_q, top_d;
   logic [YSZ-1:0]     bot_q, bot_d;
   logic [XSZ-1:0]     first_q, first_d;
   logic [XSZ-1:0]     last_q, last_d;
   logic [YSZ-1:0]     most_top_q, most_bot_q;
   logic [XSZ-1:0]     mid_pix_q;
   logic               no_star_q;
   logic [ADDR_SZ-1:0] scan_addr;
   logic               start_scan;
   logic               star_hit;

   address_translator u_addr (
      .x           (x_q),
      .y           (y_q),
      .mem_address (scan_addr)
   );

   assign start_scan = (state_q == ST_IDLE) && start;
   assign star_hit   = v_dly_q && (pixVal != BG_VAL);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SCAN;
               x_d     = '0;
               y_d     = '0;
            end
         end
         ST_SCAN: begin
            if (x_q == X_LAST) begin
               x_d = '0;
               if (y_q == Y_LAST) begin
                  y_d     = '0;
                  state_d = ST_DRAIN;
               end else begin
                  y_d = y_q + YSZ'(1);
               end
            end else begin
               x_d = x_q + XSZ'(1);
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Next-state extent values feed the DONE capture directly so the last pixel, read in DRAIN, counts.
   always_comb begin
      found_d = found_q;
      top_d   = top_q;
      bot_d   = bot_q;
      first_d = first_q;
      last_d  = last_q;
      if (start_scan) begin
         found_d = 1'b0;
         top_d   = '0;
         bot_d   = '0;
         first_d = '0;
         last_d  = '0;
      end else if (star_hit) begin
         if (!found_q) begin
            found_d = 1'b1;
            top_d   = y_dly_q;
            first_d = x_dly_q;
            last_d  = x_dly_q;
         end else if (y_dly_q == top_q) begin
            last_d = x_dly_q;
         end
         bot_d = y_dly_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         x_q        <= '0;
         y_q        <= '0;
         x_dly_q    <= '0;
         y_dly_q    <= '0;
         v_dly_q    <= 1'b0;
         found_q    <= 1'b0;
         top_q      <= '0;
         bot_q      <= '0;
         first_q    <= '0;
         last_q     <= '0;
         most_top_q <= '0;
         most_bot_q <= '0;
         mid_pix_q  <= '0;
         no_star_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         x_dly_q <= x_q;
         y_dly_q <= y_q;
         v_dly_q <= (state_q == ST_SCAN);
         found_q <= found_d;
         top_q   <= top_d;
         bot_q   <= bot_d;
         first_q <= first_d;
         last_q  <= last_d;
         if (state_q == ST_DRAIN) begin
            most_top_q <= found_d ? top_d : '0;
            most_bot_q <= found_d ? bot_d : '0;
            mid_pix_q  <= found_d ? mid_of(first_d, last_d) : '0;
            no_star_q  <= !found_d;
         end
      end
   end

   assign mem_address       = (state_q == ST_SCAN) ? scan_addr : '0;
   assign mostTop           = most_top_q;
   assign mostBottom        = most_bot_q;
   assign midPix            = mid_pix_q;
   assign noStar            = no_star_q;
   assign done              = (state_q == ST_DONE);
   assign TopandBottomFound = done && !no_star_q;

endmodule
